// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

  localparam logic [15:0] IO_ERR_DATA = 16'hDEAD;

  // An address is in range when every bit above the word-address field is zero.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned abits,
                                         input int unsigned dbits);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (abits + 1)) - 32'd1);
    if (dbits < 32) hi_mask = hi_mask & ((32'd1 << dbits) - 32'd1);
    return ((addr & hi_mask) == '0);
  endfunction

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating DMA starvation counter; hit_o flags the last wait cycle before a forced grant.
module dmem_arb_wait_ctr #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  output logic hit_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A dropped request also clears the count so a later request starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req_i || dma_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(MAX_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU fixed priority, DMA starvation-forced grant, range trap.
// Optional statistics counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DBITS    = 16,
  parameter int unsigned ABITS    = 12,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DBITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_wdata,
  output logic [DBITS-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [DBITS-1:0] dma_addr,
  input  logic [DBITS-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [DBITS-1:0] dma_rdata,
  output logic             dma_err,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din,
  output logic             mem_we,
  input  logic [DBITS-1:0] mem_dout
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]      stat_stall,
  output logic [15:0]      stat_force
`endif
);

  arb_state_e       state_q, state_d;
  logic             cpu_gnt;
  logic             dma_gnt_w;
  logic             wait_hit;
  logic             cpu_ok, dma_ok;
  logic [31:0]      cpu_a32, dma_a32;
  logic             rvalid_q, rvalid_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  always_comb begin
    cpu_a32 = '0;
    dma_a32 = '0;
    cpu_a32[DBITS-1:0] = cpu_addr;
    dma_a32[DBITS-1:0] = dma_addr;
  end

  assign cpu_ok = addr_in_range(cpu_a32, ABITS, DBITS);
  assign dma_ok = addr_in_range(dma_a32, ABITS, DBITS);

  dmem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk_i     (CLK),
    .rst_ni    (RESETN),
    .dma_req_i (dma_req),
    .dma_gnt_i (dma_gnt_w),
    .hit_o     (wait_hit)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (cpu_req && dma_req && wait_hit) state_d = ST_FORCE;
      ST_FORCE:  state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // Grants are held low throughout reset so nothing reaches memory.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt_w = 1'b0;
    if (RESETN) begin
      case (state_q)
        ST_NORMAL: begin
          if (cpu_req)      cpu_gnt   = 1'b1;
          else if (dma_req) dma_gnt_w = 1'b1;
        end
        ST_FORCE: dma_gnt_w = dma_req;
        default: ;
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign dma_gnt   = dma_gnt_w;
  assign cpu_rdata = mem_dout;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (cpu_gnt) begin
      mem_addr = cpu_addr[ABITS:1];
      mem_din  = cpu_wdata;
      mem_we   = cpu_we & cpu_ok;
    end else if (dma_gnt_w) begin
      mem_addr = dma_addr[ABITS:1];
      mem_din  = dma_wdata;
      mem_we   = dma_we & dma_ok;
    end
  end

  always_comb begin
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (dma_gnt_w) begin
      err_d = ~dma_ok;
      if (!dma_we) begin
        rvalid_d = 1'b1;
        rdata_d  = dma_ok ? mem_dout : DBITS'(IO_ERR_DATA);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;
  assign dma_err    = err_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall_q, stat_stall_d;
  logic [15:0] stat_force_q, stat_force_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_force_d = stat_force_q;
    if (cpu_stall && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 16'd1;
    if ((state_q == ST_NORMAL) && (state_d == ST_FORCE) && (stat_force_q != '1))
      stat_force_d = stat_force_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      stat_stall_q <= '0;
      stat_force_q <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_force_q <= stat_force_d;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_force = stat_force_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default parameters).
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [15:0] dma_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall, stat_force;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(
    .DBITS    (16),
    .ABITS    (12),
    .MAX_WAIT (8)
  ) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_err    (dma_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_stall (stat_stall),
    .stat_force (stat_force)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  initial begin
    RESETN   = 1'b0;
    mem_dout = '0;
    idle_inputs();
    #12;
    chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_err",    32'(dma_err),    32'd0);
    chk("rst_rdata",  32'(dma_rdata),  32'd0);
    chk("rst_gnt",    32'(dma_gnt),    32'd0);
    @(negedge CLK);
    RESETN = 1'b1;

    next_cycle();
    @(negedge CLK);
    chk("idle_addr", 32'(mem_addr), 32'd0);
    chk("idle_din",  32'(mem_din),  32'd0);
    chk("idle_we",   32'(mem_we),   32'd0);

    // DMA read alone
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0204; mem_dout = 16'h1234;
    @(negedge CLK);
    chk("dr_gnt",  32'(dma_gnt),  32'd1);
    chk("dr_addr", 32'(mem_addr), 32'h102);
    chk("dr_we",   32'(mem_we),   32'd0);
    next_cycle();
    idle_inputs();
    chk("dr_rvalid", 32'(dma_rvalid), 32'd1);
    chk("dr_rdata",  32'(dma_rdata),  32'h1234);
    chk("dr_err",    32'(dma_err),    32'd0);
    next_cycle();
    chk("dr_rvalid_drop", 32'(dma_rvalid), 32'd0);

    // CPU write alone
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 16'hBEEF;
    @(negedge CLK);
    chk("cw_we",    32'(mem_we),    32'd1);
    chk("cw_addr",  32'(mem_addr),  32'h200);
    chk("cw_din",   32'(mem_din),   32'hBEEF);
    chk("cw_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    idle_inputs();

    // Contention: three forced periods of nine cycles each
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020; mem_dout = 16'h5A5A;
    for (int c = 0; c < 27; c++) begin
      @(negedge CLK);
      if ((c % 9) == 8) begin
        chk("ct_dgnt_force",  32'(dma_gnt),   32'd1);
        chk("ct_stall_force", 32'(cpu_stall), 32'd1);
        chk("ct_addr_force",  32'(mem_addr),  32'h010);
      end else begin
        chk("ct_dgnt_cpu",  32'(dma_gnt),   32'd0);
        chk("ct_stall_cpu", 32'(cpu_stall), 32'd0);
        chk("ct_addr_cpu",  32'(mem_addr),  32'h008);
      end
      if (c == 9) begin
        chk("ct_cnt_clear", 32'(dut.u_wait_ctr.cnt_q), 32'd0);
        chk("ct_rvalid",    32'(dma_rvalid), 32'd1);
        chk("ct_rdata",     32'(dma_rdata),  32'h5A5A);
        chk("ct_cpu_rdata", 32'(cpu_rdata),  32'h5A5A);
      end
      next_cycle();
    end
    idle_inputs();
`ifdef DMEM_ARB_STATS_EN
    chk("st_force", 32'(stat_force), 32'd3);
    chk("st_stall", 32'(stat_stall), 32'd3);
`endif
    next_cycle();

    // Dropped DMA request clears the starvation count
    cpu_req = 1'b1; dma_req = 1'b1; dma_addr = 16'h0030;
    next_cycle(); next_cycle(); next_cycle();
    chk("pv_cnt3", 32'(dut.u_wait_ctr.cnt_q), 32'd3);
    dma_req = 1'b0;
    next_cycle();
    chk("pv_cnt0", 32'(dut.u_wait_ctr.cnt_q), 32'd0);
    idle_inputs();
    next_cycle();

    // Out-of-range DMA read
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'hFFF0; mem_dout = 16'h4321;
    @(negedge CLK);
    chk("or_gnt", 32'(dma_gnt), 32'd1);
    chk("or_we",  32'(mem_we),  32'd0);
    next_cycle();
    idle_inputs();
    chk("or_rvalid", 32'(dma_rvalid), 32'd1);
    chk("or_rdata",  32'(dma_rdata),  32'hDEAD);
    chk("or_err",    32'(dma_err),    32'd1);

    // Out-of-range DMA write
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hFFF8; dma_wdata = 16'h1111;
    @(negedge CLK);
    chk("ow_gnt", 32'(dma_gnt), 32'd1);
    chk("ow_we",  32'(mem_we),  32'd0);
    next_cycle();
    idle_inputs();
    chk("ow_err",    32'(dma_err),    32'd1);
    chk("ow_rvalid", 32'(dma_rvalid), 32'd0);

    // Range boundary: highest in-range byte address, then first out-of-range one
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1FFE; dma_wdata = 16'h2222;
    @(negedge CLK);
    chk("bd_in_we",   32'(mem_we),   32'd1);
    chk("bd_in_addr", 32'(mem_addr), 32'hFFF);
    chk("bd_in_din",  32'(mem_din),  32'h2222);
    next_cycle();
    chk("bd_in_err", 32'(dma_err), 32'd0);
    dma_addr = 16'h2000;
    @(negedge CLK);
    chk("bd_out_we", 32'(mem_we), 32'd0);
    next_cycle();
    idle_inputs();
    chk("bd_out_err", 32'(dma_err), 32'd1);
    next_cycle();

    // Reset while a DMA read response is pending
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300; mem_dout = 16'h7777;
    @(negedge CLK);
    chk("rs_gnt_pre", 32'(dma_gnt), 32'd1);
    RESETN = 1'b0;
    #1;
    chk("rs_gnt_low",  32'(dma_gnt),  32'd0);
    chk("rs_addr_low", 32'(mem_addr), 32'd0);
    next_cycle();
    chk("rs_rvalid_low", 32'(dma_rvalid), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    #1;
    chk("rs_gnt_first", 32'(dma_gnt),    32'd1);
    chk("rs_rvalid",    32'(dma_rvalid), 32'd0);
    next_cycle();
    idle_inputs();
    chk("rs_rvalid_after", 32'(dma_rvalid), 32'd1);
    chk("rs_rdata_after",  32'(dma_rdata),  32'h7777);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
